cdc_fifo_wr_arbiter: RTL and testbench
======================================

// Module: cdc_fifo_wr_arbiter
// PURPOSE
//   Shares the write port of one cdc_fifo among NUM_REQ requesters in the write clock domain.
//   Round-robin grant with bounded bursts; tags each beat with the requester ID.
//   Drives w_inc/w_data of the FIFO and obeys its w_full/w_almost_full flags.
//   Sits between local producers and a cdc_fifo whose DATA_WIDTH = DATA_WIDTH+ID_WIDTH.
// PARAMETERS
//   NUM_REQ     4  number of requesters, >= 2
//   DATA_WIDTH  8  payload bits per requester
//   MAX_BURST   4  max beats per grant, >= 1
//   ID_WIDTH    $clog2(NUM_REQ)  localparam, requester tag width
// PORTS
//   clk            in   1                    write-domain clock, same as the FIFO's w_clk
//   rst_n          in   1                    async active-low reset
//   in_valid       in   NUM_REQ              per-requester beat valid
//   in_data        in   NUM_REQ*DATA_WIDTH   flat payloads, req i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready       out  NUM_REQ              per-requester accept; transfer = valid & ready
//   w_full         in   1                    from FIFO
//   w_almost_full  in   1                    from FIFO
//   w_inc          out  1                    FIFO write strobe
//   w_data         out  ID_WIDTH+DATA_WIDTH  {grant_id, payload}
//   busy           out  1                    1 while in BURST
//   grant_id       out  ID_WIDTH             current/last granted requester
// BEHAVIOUR
//   Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
//   Reset (async assert): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0;
//     in_ready=0, w_inc=0, busy=0. Asserting reset mid-burst aborts it; a beat
//     not yet clocked into the FIFO is lost.
//   State: IDLE, BURST. grant_id, rr_ptr, beat_cnt are registered.
//   IDLE: in_ready=0, w_inc=0.
//     If any in_valid and !w_almost_full: grant goes to the first valid index
//     at or after rr_ptr (mod NUM_REQ); next state BURST, beat_cnt=0.
//     If w_almost_full: stay in IDLE, so no new burst starts.
//   BURST (g = grant_id): xfer = in_valid[g] & !w_full.
//     in_ready[g] = !w_full; all other in_ready = 0 (combinational).
//     w_inc = xfer; w_data = {g, in_data[g]} (combinational, same cycle).
//     On xfer: beat_cnt++.
//     Exit to IDLE, with rr_ptr <= g+1 mod NUM_REQ, when either:
//       a) xfer and beat_cnt==MAX_BURST-1, or
//       b) !in_valid[g] (requester went idle; that cycle has no transfer).
//     w_full: hold BURST with no transfer; stalls are unbounded.
//     w_almost_full does not end a running burst; w_full is the hard stop.
//   Between bursts there is exactly one IDLE bubble cycle. Max throughput is
//     MAX_BURST/(MAX_BURST+1).
//   Fairness: rr_ptr advances only on burst exit, so a continuously valid
//     requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles (FIFO not full).
//   Invariants: at most one in_ready bit set; w_inc never asserted while
//     w_full=1; w_inc==|(in_valid & in_ready).
// TESTING
//   1 Reset: rst_n=0 -> in_ready=0, w_inc=0, busy=0, grant_id=0, then rst_n=1 with all idle -> stays IDLE.
//   2 Burst cap: only req1 valid, 6 beats D0..D5, MAX_BURST=4 -> writes {1,D0..D3}, 1 bubble, then {1,D4,D5}, exit.
//   3 Round-robin: all 4 reqs valid, MAX_BURST=1 -> w_data tags 0,1,2,3,0 with a bubble cycle between each.
//   4 Full stall: w_full=1 for 5 cycles mid-burst -> w_inc=0, in_ready=0, beat_cnt held; resume with no loss or dup.
//   5 Almost full: w_almost_full=1 in IDLE with req valid -> no grant; deassert -> BURST next cycle.
//   6 Drop valid: req2 deasserts after 2 of 4 beats -> IDLE, rr_ptr=3, next grant to req3 if valid.
//   Scoreboard: per-ID ordered payload match vs FIFO write log; assert the invariants each cycle.

Source files
------------

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one cdc_fifo write port among NUM_REQ producers.
// Each accepted beat is written to the FIFO as {grant_id, payload}.
//   state | meaning
//   IDLE  | no owner; arbitrate when a requester is valid and the FIFO is not almost full
//   BURST | grant_id owns the write port until MAX_BURST beats or it drops valid
module cdc_fifo_wr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  MAX_BURST  = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_REQ-1:0]             in_ready,
  input  logic                           w_full,
  input  logic                           w_almost_full,
  output logic                           w_inc,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] w_data,
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            grant_id
);
  localparam int CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] payload [NUM_REQ];
  logic [ID_WIDTH-1:0]   pick_hi, pick_lo, pick, next_id;
  logic                  found_hi, found_any, sel_valid, xfer;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) payload[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    pick_hi   = '0;
    pick_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        found_any = 1'b1;
        pick_lo   = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= rr_ptr_q) begin
          found_hi = 1'b1;
          pick_hi  = ID_WIDTH'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  assign sel_valid = in_valid[grant_id_q];
  assign next_id   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    in_ready   = '0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_any && !w_almost_full) begin
          state_d    = BURST;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        in_ready[grant_id_q] = !w_full;
        xfer                 = sel_valid && !w_full;
        if (!sel_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_id;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_id;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_inc    = xfer;
  assign w_data   = {grant_id_q, payload[grant_id_q]};
  assign busy     = (state_q == BURST);
  assign grant_id = grant_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Bench for cdc_fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model and a per-requester ordered scoreboard.
module tb_cdc_fifo_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   in_valid, in_ready, in_valid1, in_ready1;
  logic [NR*DW-1:0] in_data, in_data1;
  logic            w_full, w_almost_full, w_inc, busy, w_inc1, busy1;
  logic [IDW+DW-1:0] w_data, w_data1;
  logic [IDW-1:0]  grant_id, grant_id1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rq  [NR][$];
  logic [DW-1:0] sbq [NR][$];
  logic [NR-1:0] en;

  logic            last_inc, last_busy;
  logic [IDW+DW-1:0] last_data;
  logic [IDW-1:0]  last_gid;
  logic [NR-1:0]   last_ready;

  int m_busy, m_g, m_n, m_ptr;

  always #5 clk = ~clk;

  cdc_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_full(w_full), .w_almost_full(w_almost_full), .w_inc(w_inc), .w_data(w_data),
    .busy(busy), .grant_id(grant_id));

  cdc_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .w_full(1'b0), .w_almost_full(1'b0), .w_inc(w_inc1), .w_data(w_data1),
    .busy(busy1), .grant_id(grant_id1));

  // Per-cycle reference model, invariants and write-log scoreboard for u_dut.
  always @(negedge clk) begin
    logic [NR-1:0]     e_ready;
    logic              e_inc;
    logic [IDW+DW-1:0] e_data;
    int                id;
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_n = 0; m_ptr = 0;
    end else begin
      e_ready = '0; e_inc = 1'b0; e_data = '0;
      if (m_busy != 0) begin
        if (!w_full) e_ready[m_g] = 1'b1;
        e_inc  = in_valid[m_g] && !w_full;
        e_data = {IDW'(m_g), in_data[m_g*DW +: DW]};
      end
      total++;
      if (in_ready !== e_ready) begin
        bad++; $display("FAIL model_in_ready t=%0t got %b want %b", $time, in_ready, e_ready);
      end
      total++;
      if (w_inc !== e_inc) begin
        bad++; $display("FAIL model_w_inc t=%0t got %b want %b", $time, w_inc, e_inc);
      end
      if (e_inc) begin
        total++;
        if (w_data !== e_data) begin
          bad++; $display("FAIL model_w_data t=%0t got %h want %h", $time, w_data, e_data);
        end
      end
      total++;
      if (busy !== (m_busy != 0)) begin
        bad++; $display("FAIL model_busy t=%0t got %b want %0d", $time, busy, m_busy);
      end
      total++;
      if (grant_id !== IDW'(m_g)) begin
        bad++; $display("FAIL model_grant_id t=%0t got %0d want %0d", $time, grant_id, m_g);
      end
      total++;
      if ($countones(in_ready) > 1 || (w_inc === 1'b1 && w_full === 1'b1) ||
          w_inc !== |(in_valid & in_ready)) begin
        bad++; $display("FAIL invariant t=%0t got ready=%b inc=%b full=%b valid=%b want onehot0/no-write-when-full/inc==|(v&r)",
                        $time, in_ready, w_inc, w_full, in_valid);
      end
      if (w_inc === 1'b1) begin
        id = int'(w_data[DW +: IDW]);
        total++;
        if (sbq[id].size() == 0) begin
          bad++; $display("FAIL scoreboard_extra t=%0t got id=%0d data=%h want no write", $time, id, w_data[DW-1:0]);
        end else begin
          if (w_data[DW-1:0] !== sbq[id][0]) begin
            bad++; $display("FAIL scoreboard_order t=%0t id=%0d got %h want %h", $time, id, w_data[DW-1:0], sbq[id][0]);
          end
          void'(sbq[id].pop_front());
        end
      end
      for (int i = 0; i < NR; i++)
        if (in_valid[i] && in_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (m_busy == 0) begin
        if (in_valid != '0 && !w_almost_full) begin
          for (int k = NR - 1; k >= 0; k--)
            if (in_valid[(m_ptr + k) % NR]) m_g = (m_ptr + k) % NR;
          m_busy = 1; m_n = 0;
        end
      end else if (!in_valid[m_g]) begin
        m_busy = 0; m_ptr = (m_g + 1) % NR;
      end else if (!w_full) begin
        m_n++;
        if (m_n == MB) begin m_busy = 0; m_ptr = (m_g + 1) % NR; end
      end
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int i, input logic [DW-1:0] val);
    rq[i].push_back(val);
    sbq[i].push_back(val);
  endtask

  task automatic tick(input bit full, input bit af);
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    v = '0; d = '0;
    for (int i = 0; i < NR; i++)
      if (en[i] && rq[i].size() > 0) begin v[i] = 1'b1; d[i*DW +: DW] = rq[i][0]; end
    in_valid = v; in_data = d; w_full = full; w_almost_full = af;
    @(negedge clk); #1;
    last_inc = w_inc; last_data = w_data; last_busy = busy; last_gid = grant_id; last_ready = in_ready;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    en = '1;
    for (int c = 0; c < 400 && !done; c++) begin
      tick(1'b0, 1'b0);
      if (all_empty() && !last_busy) done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL drain_timeout got pending beats after 400 cycles want all written"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; in_valid = '0; in_data = '0; w_full = 1'b0; w_almost_full = 1'b0;
    in_valid1 = '0; in_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, w_inc, busy, grant_id} !== '0) begin
      bad++; $display("FAIL reset_outputs got ready=%b inc=%b busy=%b gid=%0d want all 0", in_ready, w_inc, busy, grant_id);
    end
    total++;
    if ({in_ready1, w_inc1, busy1, grant_id1} !== '0) begin
      bad++; $display("FAIL reset_outputs_mb1 got ready=%b inc=%b busy=%b gid=%0d want all 0", in_ready1, w_inc1, busy1, grant_id1);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0);
      total++;
      if (last_busy !== 1'b0 || last_inc !== 1'b0) begin
        bad++; $display("FAIL reset_idle c=%0d got busy=%b inc=%b want 0 0", c, last_busy, last_inc);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [9:0]        got;
    logic [IDW+DW-1:0] wd [$];
    logic [IDW+DW-1:0] exp_w;
    got = '0;
    en = 4'b0010;
    for (int k = 0; k < 6; k++) push(1, DW'(8'hA0 + k));
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b0);
      got[c] = last_inc;
      if (last_inc) wd.push_back(last_data);
    end
    total++;
    if (got !== 10'b0011011110) begin bad++; $display("FAIL burst_cap_pattern got %b want %b", got, 10'b0011011110); end
    total++;
    if (wd.size() != 6) begin bad++; $display("FAIL burst_cap_count got %0d want 6", wd.size()); end
    for (int k = 0; k < wd.size() && k < 6; k++) begin
      exp_w = {2'd1, DW'(8'hA0 + k)};
      total++;
      if (wd[k] !== exp_w) begin bad++; $display("FAIL burst_cap_data k=%0d got %h want %h", k, wd[k], exp_w); end
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [9:0]      got;
    logic [IDW-1:0]  tags [$];
    logic [IDW-1:0]  exp_tag [5];
    logic [DW-1:0]   pay [$];
    exp_tag = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    got = '0;
    en = '0; in_valid = '0;
    in_data1  = {8'h33, 8'h22, 8'h11, 8'h00};
    in_valid1 = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      got[c] = w_inc1;
      if (w_inc1) begin tags.push_back(w_data1[DW +: IDW]); pay.push_back(w_data1[DW-1:0]); end
      @(posedge clk); #1;
    end
    in_valid1 = '0;
    total++;
    if (got !== 10'b1010101010) begin bad++; $display("FAIL rr_pattern got %b want %b", got, 10'b1010101010); end
    total++;
    if (tags.size() != 5) begin bad++; $display("FAIL rr_count got %0d want 5", tags.size()); end
    for (int k = 0; k < tags.size() && k < 5; k++) begin
      total++;
      if (tags[k] !== exp_tag[k] || pay[k] !== DW'(8'h11 * exp_tag[k])) begin
        bad++; $display("FAIL rr_tag k=%0d got tag %0d data %h want tag %0d data %h", k, tags[k], pay[k], exp_tag[k], DW'(8'h11 * exp_tag[k]));
      end
    end
  endtask

  task automatic test_full_stall();
    logic [11:0]   got;
    logic [NR-1:0] stall_ready;
    logic [DW-1:0] pay [$];
    got = '0; stall_ready = '0;
    en = 4'b0001;
    for (int k = 0; k < 8; k++) push(0, DW'(8'h50 + k));
    for (int c = 0; c < 12; c++) begin
      tick(c >= 3 && c <= 7, 1'b0);
      got[c] = last_inc;
      if (c >= 3 && c <= 7) stall_ready = stall_ready | last_ready;
      if (last_inc) pay.push_back(last_data[DW-1:0]);
    end
    total++;
    if (got !== 12'b101100000110) begin bad++; $display("FAIL stall_pattern got %b want %b", got, 12'b101100000110); end
    total++;
    if (stall_ready !== '0) begin bad++; $display("FAIL stall_ready got %b want 0000", stall_ready); end
    for (int k = 0; k < pay.size(); k++) begin
      total++;
      if (pay[k] !== DW'(8'h50 + k)) begin bad++; $display("FAIL stall_data k=%0d got %h want %h", k, pay[k], DW'(8'h50 + k)); end
    end
    drain();
  endtask

  task automatic test_almost_full();
    logic [4:0] got;
    got = '0;
    en = 4'b0100;
    push(2, 8'h60); push(2, 8'h61);
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, c < 3);
      got[c] = last_busy;
    end
    total++;
    if (got !== 5'b10000) begin bad++; $display("FAIL af_busy got %b want %b", got, 5'b10000); end
    total++;
    if (last_inc !== 1'b1 || last_gid !== 2'd2 || last_data !== {2'd2, 8'h60}) begin
      bad++; $display("FAIL af_first_beat got inc=%b gid=%0d data=%h want 1 2 %h", last_inc, last_gid, last_data, {2'd2, 8'h60});
    end
    drain();
  endtask

  task automatic test_drop_valid();
    en = 4'b0100;
    for (int k = 0; k < 4; k++) push(2, DW'(8'h70 + k));
    push(3, 8'h80); push(3, 8'h81);
    push(0, 8'h90); push(0, 8'h91);
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
    en = 4'b1001;
    tick(1'b0, 1'b0);
    total++;
    if (last_busy !== 1'b1 || last_inc !== 1'b0) begin
      bad++; $display("FAIL drop_exit_cycle got busy=%b inc=%b want 1 0", last_busy, last_inc);
    end
    tick(1'b0, 1'b0);
    total++;
    if (last_busy !== 1'b0) begin bad++; $display("FAIL drop_bubble got busy=%b want 0", last_busy); end
    tick(1'b0, 1'b0);
    total++;
    if (last_gid !== 2'd3 || last_inc !== 1'b1 || last_data !== {2'd3, 8'h80}) begin
      bad++; $display("FAIL drop_next_grant got gid=%0d inc=%b data=%h want 3 1 %h", last_gid, last_inc, last_data, {2'd3, 8'h80});
    end
    drain();
  endtask

  task automatic test_random();
    int i;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(1) == 0) begin
        i = $urandom_range(NR - 1);
        if (rq[i].size() < 6) push(i, DW'($urandom));
      end
      en = NR'($urandom);
      tick($urandom_range(4) == 0, $urandom_range(3) == 0);
    end
    drain();
    for (int k = 0; k < NR; k++) begin
      total++;
      if (sbq[k].size() != 0) begin bad++; $display("FAIL random_lost id=%0d got %0d unwritten want 0", k, sbq[k].size()); end
    end
  endtask

  task automatic test_reset_abort();
    en = 4'b1000;
    for (int k = 0; k < 4; k++) push(3, DW'(8'hB0 + k));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, w_inc, busy, grant_id} !== '0) begin
      bad++; $display("FAIL abort_outputs got ready=%b inc=%b busy=%b gid=%0d want all 0", in_ready, w_inc, busy, grant_id);
    end
    for (int k = 0; k < NR; k++) begin rq[k].delete(); sbq[k].delete(); end
    en = '0; in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 8'hC0); push(3, 8'hC3);
    en = 4'b1001;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    total++;
    if (last_gid !== 2'd0 || last_data !== {2'd0, 8'hC0}) begin
      bad++; $display("FAIL abort_rr_restart got gid=%0d data=%h want 0 %h", last_gid, last_data, {2'd0, 8'hC0});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_burst_cap();
    test_round_robin();
    test_full_stall();
    test_almost_full();
    test_drop_valid();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish before 1000000");
    $fatal(1);
  end

endmodule
